// File: rtl/kf8253_bus_sequencer.sv
// rtl/kf8253_bus_sequencer.sv - expands timer commands into timed KF8253 CPU bus cycles
module kf8253_bus_sequencer #(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int HOLD_CYCLES     = 1,
    parameter int RECOVERY_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cmd,
    input  logic [1:0]  req_counter,
    input  logic [1:0]  req_rw,
    input  logic [2:0]  req_mode,
    input  logic        req_bcd,
    input  logic [15:0] req_value,
    output logic        rsp_valid,
    output logic        rsp_error,
    output logic [15:0] rsp_data,
    output logic        chip_select_n,
    output logic        read_enable_n,
    output logic        write_enable_n,
    output logic [1:0]  address,
    output logic [7:0]  data_bus_out,
    output logic        data_bus_oe,
    input  logic [7:0]  data_bus_in
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_RECOVER, ST_DONE
    } state_t;

    localparam logic [1:0] CMD_PROGRAM = 2'b00;
    localparam logic [1:0] CMD_LATCH   = 2'b01;
    localparam logic [1:0] CMD_RELOAD  = 2'b10;

    localparam logic [7:0] SETUP_LOAD    = 8'(SETUP_CYCLES);
    localparam logic [7:0] STROBE_LOAD   = 8'(STROBE_CYCLES);
    localparam logic [7:0] HOLD_LOAD     = 8'(HOLD_CYCLES);
    localparam logic [7:0] RECOVERY_LOAD = 8'(RECOVERY_CYCLES);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [1:0]  idx, idx_n;
    logic        pending;
    logic [1:0]  cmd_q, counter_q, rw_q;
    logic [2:0]  mode_q;
    logic        bcd_q;
    logic [15:0] value_q;
    logic [7:0]  lsb_q, msb_q;

    logic        accept;
    logic        illegal;
    logic [1:0]  last_idx;
    logic [7:0]  control_word;
    logic [1:0]  count_idx;
    logic [7:0]  count_byte;
    logic        acc_write;
    logic [1:0]  acc_addr;
    logic [7:0]  acc_data;
    logic        sample_read;

    logic        cs_n_n, re_n_n, we_n_n, oe_n;
    logic [1:0]  addr_n;
    logic [7:0]  dout_n;
    logic        ready_n, rsp_valid_n, rsp_error_n;
    logic [15:0] rsp_data_n;

    assign accept  = req_valid & req_ready;
    assign illegal = (cmd_q == 2'b11) || (counter_q == 2'b11) ||
                     ((cmd_q != CMD_LATCH) && (rw_q == 2'b00));

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        case (state)
            ST_IDLE: begin
                idx_n = 2'd0;
                if (pending) begin
                    if (illegal) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_SETUP;
                        cnt_n   = SETUP_LOAD;
                    end
                end
            end
            ST_SETUP: begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_n = ST_STROBE;
                    cnt_n   = STROBE_LOAD;
                end
            end
            ST_STROBE: begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_n = ST_HOLD;
                    cnt_n   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_n = ST_RECOVER;
                    cnt_n   = RECOVERY_LOAD;
                end
            end
            ST_RECOVER: begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    if (idx == last_idx) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_SETUP;
                        cnt_n   = SETUP_LOAD;
                        idx_n   = idx + 2'd1;
                    end
                end
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Access list: index 0 is the control/latch word unless the command is RELOAD.
    always_comb begin
        last_idx = 2'd0;
        case (cmd_q)
            CMD_PROGRAM: last_idx = (rw_q == 2'b11) ? 2'd2 : 2'd1;
            CMD_RELOAD:  last_idx = (rw_q == 2'b11) ? 2'd1 : 2'd0;
            default:     last_idx = 2'd2;
        endcase
        control_word = {counter_q, (cmd_q == CMD_LATCH) ? 2'b00 : rw_q, mode_q, bcd_q};
        count_idx    = (cmd_q == CMD_RELOAD) ? idx_n : idx_n - 2'd1;
        count_byte   = ((count_idx == 2'd0) && (rw_q != 2'b10)) ? value_q[7:0] : value_q[15:8];
        acc_write    = 1'b1;
        acc_addr     = counter_q;
        acc_data     = count_byte;
        if ((cmd_q != CMD_RELOAD) && (idx_n == 2'd0)) begin
            acc_addr = 2'd3;
            acc_data = control_word;
        end else if (cmd_q == CMD_LATCH) begin
            acc_write = 1'b0;
            acc_data  = 8'h00;
        end
    end

    always_comb begin
        cs_n_n      = 1'b1;
        re_n_n      = 1'b1;
        we_n_n      = 1'b1;
        oe_n        = 1'b0;
        addr_n      = 2'd0;
        dout_n      = 8'h00;
        ready_n     = (state_n == ST_IDLE) && !accept;
        rsp_valid_n = (state_n == ST_DONE);
        rsp_error_n = (state_n == ST_DONE) && illegal;
        rsp_data_n  = 16'h0000;
        if ((state_n == ST_DONE) && !illegal && (cmd_q == CMD_LATCH))
            rsp_data_n = {msb_q, lsb_q};
        case (state_n)
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                cs_n_n = 1'b0;
                addr_n = acc_addr;
                oe_n   = acc_write;
                dout_n = acc_data;
                if (state_n == ST_STROBE) begin
                    we_n_n = !acc_write;
                    re_n_n = acc_write;
                end
            end
            ST_RECOVER: begin
                addr_n = acc_addr;
                dout_n = acc_data;
            end
            default: ;
        endcase
    end

    assign sample_read = (state == ST_STROBE) && (cnt == 8'd1) && !acc_write;

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            cnt            <= 8'd0;
            idx            <= 2'd0;
            pending        <= 1'b0;
            cmd_q          <= 2'b00;
            counter_q      <= 2'b00;
            rw_q           <= 2'b00;
            mode_q         <= 3'd0;
            bcd_q          <= 1'b0;
            value_q        <= 16'h0000;
            lsb_q          <= 8'h00;
            msb_q          <= 8'h00;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_error      <= 1'b0;
            rsp_data       <= 16'h0000;
            chip_select_n  <= 1'b1;
            read_enable_n  <= 1'b1;
            write_enable_n <= 1'b1;
            address        <= 2'd0;
            data_bus_out   <= 8'h00;
            data_bus_oe    <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            idx     <= idx_n;
            pending <= accept;
            if (accept) begin
                cmd_q     <= req_cmd;
                counter_q <= req_counter;
                rw_q      <= req_rw;
                mode_q    <= req_mode;
                bcd_q     <= req_bcd;
                value_q   <= req_value;
            end
            if (sample_read) begin
                if (idx == 2'd1) lsb_q <= data_bus_in;
                else             msb_q <= data_bus_in;
            end
            req_ready      <= ready_n;
            rsp_valid      <= rsp_valid_n;
            rsp_error      <= rsp_error_n;
            rsp_data       <= rsp_data_n;
            chip_select_n  <= cs_n_n;
            read_enable_n  <= re_n_n;
            write_enable_n <= we_n_n;
            address        <= addr_n;
            data_bus_out   <= dout_n;
            data_bus_oe    <= oe_n;
        end
    end

endmodule

// File: tb/tb_kf8253_bus_sequencer.sv
// tb/tb_kf8253_bus_sequencer.sv - scoreboard bench for kf8253_bus_sequencer
module tb_kf8253_bus_sequencer;

    logic        clock = 1'b0;
    logic        reset_in = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_cmd = 2'b00;
    logic [1:0]  req_counter = 2'b00;
    logic [1:0]  req_rw = 2'b00;
    logic [2:0]  req_mode = 3'd0;
    logic        req_bcd = 1'b0;
    logic [15:0] req_value = 16'h0000;
    logic        rsp_valid;
    logic        rsp_error;
    logic [15:0] rsp_data;
    logic        chip_select_n;
    logic        read_enable_n;
    logic        write_enable_n;
    logic [1:0]  address;
    logic [7:0]  data_bus_out;
    logic        data_bus_oe;
    logic [7:0]  data_bus_in;

    kf8253_bus_sequencer dut (
        .clock(clock), .reset_in(reset_in),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_counter(req_counter), .req_rw(req_rw),
        .req_mode(req_mode), .req_bcd(req_bcd), .req_value(req_value),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_data(rsp_data),
        .chip_select_n(chip_select_n), .read_enable_n(read_enable_n),
        .write_enable_n(write_enable_n), .address(address),
        .data_bus_out(data_bus_out), .data_bus_oe(data_bus_oe),
        .data_bus_in(data_bus_in)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic wr; logic [1:0] addr; logic [7:0] data; } acc_t;
    typedef struct packed { logic err; logic [15:0] data; logic [7:0] lat; } rsp_t;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    int   checks = 0;
    int   failures = 0;
    int   outstanding = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic rd_sel = 1'b0;

    assign data_bus_in = rd_sel ? 8'hAB : 8'hCD;

    always @(posedge clock) begin
        if (!reset_in && req_valid && req_ready) begin
            checks++;
            if (outstanding != 0) begin
                failures++;
                $display("FAIL accept_while_busy outstanding=%0d required=0", outstanding);
            end
            outstanding++;
            acc_cyc = cyc;
        end
        cyc++;
    end

    logic prev_we = 1'b1, prev_re = 1'b1, prev_cs = 1'b1, overlap = 1'b0, seen_cs = 1'b0;
    int   low_cnt = 0, gap = 0;

    always @(negedge clock) begin
        if (reset_in) begin
            prev_we = 1'b1; prev_re = 1'b1; prev_cs = 1'b1;
            overlap = 1'b0; seen_cs = 1'b0; low_cnt = 0; gap = 0;
        end else begin
            if (chip_select_n) gap++;
            if (prev_cs && !chip_select_n) begin
                if (seen_cs) begin
                    checks++;
                    if (gap < 4) begin
                        failures++;
                        $display("FAIL recovery_gap got=%0d required>=4", gap);
                    end
                end
                seen_cs = 1'b1;
                gap = 0;
            end
            if ((prev_we && !write_enable_n) || (prev_re && !read_enable_n)) begin
                checks++;
                if (exp_acc.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_access wr_n=%b addr=%0d data=%h", write_enable_n, address, data_bus_out);
                end else begin
                    acc_t e;
                    logic [11:0] got, want;
                    e = exp_acc.pop_front();
                    if (!write_enable_n) begin
                        got  = {chip_select_n, data_bus_oe, address, data_bus_out};
                        want = {1'b0, 1'b1, e.addr, e.data};
                    end else begin
                        got  = {chip_select_n, data_bus_oe, address, 8'h00};
                        want = {1'b0, 1'b0, e.addr, 8'h00};
                    end
                    if (!write_enable_n != e.wr || got != want) begin
                        failures++;
                        $display("FAIL bus_access got wr=%b cs_n/oe/addr/data=%h required wr=%b %h",
                                 !write_enable_n, got, e.wr, want);
                    end
                end
            end
            if (!write_enable_n && !read_enable_n) overlap = 1'b1;
            if (!write_enable_n || !read_enable_n) begin
                low_cnt++;
            end else if (!prev_we || !prev_re) begin
                checks++;
                if (low_cnt != 2 || overlap) begin
                    failures++;
                    $display("FAIL strobe_width got=%0d overlap=%b required=2 overlap=0", low_cnt, overlap);
                end
                low_cnt = 0;
                overlap = 1'b0;
            end
            if (!prev_re && read_enable_n) rd_sel = ~rd_sel;
            if (rsp_valid) begin
                checks++;
                if (exp_rsp.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp err=%b data=%h", rsp_error, rsp_data);
                end else begin
                    rsp_t e, g;
                    e = exp_rsp.pop_front();
                    g = {rsp_error, rsp_data, 8'(cyc - acc_cyc - 1)};
                    if (g != e) begin
                        failures++;
                        $display("FAIL response got err=%b data=%h lat=%0d required err=%b data=%h lat=%0d",
                                 g.err, g.data, g.lat, e.err, e.data, e.lat);
                    end
                end
                if (outstanding > 0) outstanding--;
            end
            prev_we = write_enable_n;
            prev_re = read_enable_n;
            prev_cs = chip_select_n;
        end
    end

    task automatic exp_w(input logic [1:0] a, input logic [7:0] d);
        exp_acc.push_back('{wr: 1'b1, addr: a, data: d});
    endtask

    task automatic exp_r(input logic [1:0] a);
        exp_acc.push_back('{wr: 1'b0, addr: a, data: 8'h00});
    endtask

    task automatic exp_done(input logic err, input logic [15:0] d, input logic [7:0] lat);
        exp_rsp.push_back('{err: err, data: d, lat: lat});
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [1:0] ctr, input logic [1:0] rw,
                         input logic [2:0] mode, input logic [15:0] val, input bit keep);
        bit ok;
        req_cmd = cmd; req_counter = ctr; req_rw = rw;
        req_mode = mode; req_bcd = 1'b0; req_value = val;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout cmd=%0d ready=%b required=1", cmd, req_ready);
        end
        @(negedge clock);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (outstanding == 0 && exp_rsp.size() == 0 && exp_acc.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout pending_rsp=%0d pending_acc=%0d required=0", exp_rsp.size(), exp_acc.size());
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, got, want);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset_in = 1'b0;
        @(negedge clock);
        check1("reset_req_ready", req_ready, 1'b1);
        check1("reset_cs_n", chip_select_n, 1'b1);
        check1("reset_we_n", write_enable_n, 1'b1);
        check1("reset_re_n", read_enable_n, 1'b1);
        check1("reset_oe", data_bus_oe, 1'b0);
        check1("reset_rsp_valid", rsp_valid, 1'b0);
        checks++;
        if ({address, data_bus_out, rsp_data} !== 26'h0) begin
            failures++;
            $display("FAIL reset_bus got addr=%0d data=%h rsp=%h required 0", address, data_bus_out, rsp_data);
        end

        exp_w(2'd3, 8'h36); exp_w(2'd0, 8'h34); exp_w(2'd0, 8'h12);
        exp_done(1'b0, 16'h0000, 8'd25);
        issue(2'b00, 2'd0, 2'b11, 3'd3, 16'h1234, 1'b0);
        wait_idle();

        exp_w(2'd3, 8'h80); exp_r(2'd2); exp_r(2'd2);
        exp_done(1'b0, 16'hABCD, 8'd25);
        issue(2'b01, 2'd2, 2'b00, 3'd0, 16'h0000, 1'b0);
        wait_idle();

        exp_w(2'd1, 8'hFF);
        exp_done(1'b0, 16'h0000, 8'd9);
        issue(2'b10, 2'd1, 2'b01, 3'd0, 16'h00FF, 1'b0);
        wait_idle();

        exp_done(1'b1, 16'h0000, 8'd1);
        issue(2'b00, 2'd0, 2'b00, 3'd2, 16'h5555, 1'b0);
        wait_idle();
        exp_done(1'b1, 16'h0000, 8'd1);
        issue(2'b11, 2'd1, 2'b11, 3'd0, 16'h5555, 1'b0);
        wait_idle();
        exp_done(1'b1, 16'h0000, 8'd1);
        issue(2'b00, 2'd3, 2'b11, 3'd0, 16'h5555, 1'b0);
        wait_idle();

        // Two commands with req_valid held high throughout.
        exp_w(2'd0, 8'hAB);
        exp_done(1'b0, 16'h0000, 8'd9);
        exp_w(2'd2, 8'h78); exp_w(2'd2, 8'h56);
        exp_done(1'b0, 16'h0000, 8'd17);
        issue(2'b10, 2'd0, 2'b10, 3'd0, 16'hAB12, 1'b1);
        issue(2'b10, 2'd2, 2'b11, 3'd0, 16'h5678, 1'b0);
        wait_idle();

        // PROGRAM mode 2 on counter 1, reset during the second write strobe.
        exp_w(2'd3, 8'h74); exp_w(2'd1, 8'h21); exp_w(2'd1, 8'h43);
        issue(2'b00, 2'd1, 2'b11, 3'd2, 16'h4321, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            if (exp_acc.size() <= 1) break;
        end
        #3 reset_in = 1'b1;
        #1;
        check1("midreset_we_n", write_enable_n, 1'b1);
        check1("midreset_cs_n", chip_select_n, 1'b1);
        exp_acc.delete();
        exp_rsp.delete();
        outstanding = 0;
        repeat (2) @(negedge clock);
        reset_in = 1'b0;
        @(negedge clock);
        check1("postreset_req_ready", req_ready, 1'b1);
        check1("postreset_rsp_valid", rsp_valid, 1'b0);
        repeat (30) @(negedge clock);

        exp_w(2'd2, 8'h9A);
        exp_done(1'b0, 16'h0000, 8'd9);
        issue(2'b10, 2'd2, 2'b10, 3'd0, 16'h9A00, 1'b0);
        wait_idle();

        checks++;
        if (exp_acc.size() != 0 || exp_rsp.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations acc=%0d rsp=%0d required=0", exp_acc.size(), exp_rsp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
